// File: rtl/lc3_alu_pkg.sv
// Shared types and constants for the LC-3 operand stage: opcodes, ALU
// control encoding, register/word types and the imm5 sign extender.
package lc3_alu_pkg;

    localparam int DATA_W    = 16;
    localparam int NUM_REGS  = 8;
    localparam int REG_IDX_W = 3;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_AND  = 2'b01,
        ALU_NOT  = 2'b10,
        ALU_PASS = 2'b11
    } alu_ctrl_e;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]    word_t;

    // imm5 (-16..+15) widened to a full data word
    function automatic word_t sext_imm5(input logic [4:0] imm);
        return {{(DATA_W-5){imm[4]}}, imm};
    endfunction

endpackage

// File: rtl/lc3_regfile.sv
// 8x16 register file: two asynchronous read ports, one synchronous write
// port, synchronous active-high reset clearing every register (R0 included).
module lc3_regfile
    import lc3_alu_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  reg_idx_t rd_addr1,
    input  reg_idx_t rd_addr2,
    output word_t    rd_data1,
    output word_t    rd_data2,
    input  logic     wr_en,
    input  reg_idx_t wr_addr,
    input  word_t    wr_data
);

    word_t regs_q [NUM_REGS];
    word_t regs_d [NUM_REGS];

    // next-state: single write port, reset wins over a same-cycle write
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_d[i] = '0;
            end
        end else if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // register array storage
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
        end
    end

    assign rd_data1 = regs_q[rd_addr1];
    assign rd_data2 = regs_q[rd_addr2];

endmodule

// File: rtl/lc3_operand_stage.sv
// LC-3 decode/operand-fetch stage feeding the ALU. Decodes ADD/AND/NOT,
// reads operands from the register file (with write-read bypass) and holds a
// one-entry registered output for the ALU.
//
// Handshake: a word moves on any edge where valid && ready are both high.
// On the input side in_ready = !out_valid || out_ready, so a new
// instruction can be accepted in the same cycle the held one is taken,
// giving one instruction per cycle. While out_valid && !out_ready the held
// outputs stay stable, except that a register write to one of the held
// entry's register sources refreshes that operand with the written data.
module lc3_operand_stage
    import lc3_alu_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] IR,
    input  logic        wb_en,
    input  logic [2:0]  wb_dr,
    input  logic [15:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] SR1,
    output logic [15:0] SR2,
    output logic [1:0]  ALUControl,
    output logic [2:0]  DR,
    output logic        illegal_op
);

    // held output entry
    logic      out_valid_q, out_valid_d;
    word_t     sr1_q, sr1_d;
    word_t     sr2_q, sr2_d;
    alu_ctrl_e alu_q, alu_d;
    reg_idx_t  dr_q, dr_d;
    logic      illegal_q, illegal_d;
    // source bookkeeping for the held-entry refresh
    reg_idx_t  src1_q, src1_d;
    reg_idx_t  src2_q, src2_d;
    logic      src2_reg_q, src2_reg_d;

    // decode signals
    logic [3:0] opcode;
    reg_idx_t   ir_src1;
    reg_idx_t   ir_src2;
    logic       ir_imm;
    logic       is_add;
    logic       is_and;
    logic       is_not;
    logic       is_alu;
    logic       accept;
    logic       transfer;
    logic       hold;

    word_t rf_rd1;
    word_t rf_rd2;
    word_t op1;
    word_t op2;

    lc3_regfile u_regfile (
        .clk      (Clk),
        .reset    (Reset),
        .rd_addr1 (ir_src1),
        .rd_addr2 (ir_src2),
        .rd_data1 (rf_rd1),
        .rd_data2 (rf_rd2),
        .wr_en    (wb_en),
        .wr_addr  (wb_dr),
        .wr_data  (wb_data)
    );

    assign opcode  = IR[15:12];
    assign ir_src1 = IR[8:6];
    assign ir_src2 = IR[2:0];
    assign ir_imm  = IR[5];
    assign is_add  = (opcode == OP_ADD);
    assign is_and  = (opcode == OP_AND);
    assign is_not  = (opcode == OP_NOT);
    assign is_alu  = is_add || is_and || is_not;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign transfer = out_valid_q && out_ready;
    assign hold     = out_valid_q && !out_ready;

    // operand read with bypass of a same-cycle register write
    always_comb begin
        op1 = rf_rd1;
        op2 = rf_rd2;
        if (wb_en && (wb_dr == ir_src1)) begin
            op1 = wb_data;
        end
        if (wb_en && (wb_dr == ir_src2)) begin
            op2 = wb_data;
        end
    end

    // next-state for the output entry: accept/decode, drain, or hold+refresh
    always_comb begin
        out_valid_d = out_valid_q;
        sr1_d       = sr1_q;
        sr2_d       = sr2_q;
        alu_d       = alu_q;
        dr_d        = dr_q;
        illegal_d   = 1'b0;
        src1_d      = src1_q;
        src2_d      = src2_q;
        src2_reg_d  = src2_reg_q;

        if (accept) begin
            if (is_alu) begin
                out_valid_d = 1'b1;
                dr_d        = IR[11:9];
                src1_d      = ir_src1;
                src2_d      = ir_src2;
                sr1_d       = op1;
                if (is_not) begin
                    alu_d      = ALU_NOT;
                    sr2_d      = '0;
                    src2_reg_d = 1'b0;
                end else begin
                    alu_d      = is_add ? ALU_ADD : ALU_AND;
                    src2_reg_d = !ir_imm;
                    sr2_d      = ir_imm ? sext_imm5(IR[4:0]) : op2;
                end
            end else begin
                // non-ALU opcode: consumed, flagged, no output produced
                out_valid_d = 1'b0;
                illegal_d   = 1'b1;
            end
        end else if (transfer) begin
            out_valid_d = 1'b0;
        end else if (hold && wb_en) begin
            if (wb_dr == src1_q) begin
                sr1_d = wb_data;
            end
            if (src2_reg_q && (wb_dr == src2_q)) begin
                sr2_d = wb_data;
            end
        end

        if (Reset) begin
            out_valid_d = 1'b0;
            sr1_d       = '0;
            sr2_d       = '0;
            alu_d       = ALU_ADD;
            dr_d        = '0;
            illegal_d   = 1'b0;
            src1_d      = '0;
            src2_d      = '0;
            src2_reg_d  = 1'b0;
        end
    end

    // output entry registers
    always_ff @(posedge Clk) begin
        out_valid_q <= out_valid_d;
        sr1_q       <= sr1_d;
        sr2_q       <= sr2_d;
        alu_q       <= alu_d;
        dr_q        <= dr_d;
        illegal_q   <= illegal_d;
        src1_q      <= src1_d;
        src2_q      <= src2_d;
        src2_reg_q  <= src2_reg_d;
    end

    assign out_valid  = out_valid_q;
    assign SR1        = sr1_q;
    assign SR2        = sr2_q;
    assign ALUControl = alu_q;
    assign DR         = dr_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_lc3_operand_stage.sv
// Bench for lc3_operand_stage: directed scenarios followed by a random
// instruction/writeback/backpressure stream, all compared with a
// behavioural model of the stage.
module tb_lc3_operand_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] IR;
    logic        wb_en;
    logic [2:0]  wb_dr;
    logic [15:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] SR1;
    logic [15:0] SR2;
    logic [1:0]  ALUControl;
    logic [2:0]  DR;
    logic        illegal_op;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [15:0] m_rf [8];
    logic        m_valid;
    logic [15:0] m_sr1;
    logic [15:0] m_sr2;
    logic [1:0]  m_alu;
    logic [2:0]  m_dr;
    logic        m_illegal;
    int          m_s1;
    int          m_s2;     // -1 when SR2 is not a register source
    int          n_transfers;

    lc3_operand_stage dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .IR         (IR),
        .wb_en      (wb_en),
        .wb_dr      (wb_dr),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .SR1        (SR1),
        .SR2        (SR2),
        .ALUControl (ALUControl),
        .DR         (DR),
        .illegal_op (illegal_op)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_read(input int idx);
        if (wb_en && (int'(wb_dr) == idx)) return wb_data;
        return m_rf[idx];
    endfunction

    // one clock: drive inputs, check in_ready, advance model, check outputs
    task automatic step(input logic rst, input logic iv, input logic [15:0] ir,
                        input logic we, input logic [2:0] wdr, input logic [15:0] wd,
                        input logic ordy);
        logic acc;
        logic [3:0] op;
        int s1;
        int s2;
        Reset = rst; in_valid = iv; IR = ir;
        wb_en = we; wb_dr = wdr; wb_data = wd; out_ready = ordy;
        #1;
        chk("in_ready", {15'd0, in_ready}, {15'd0, (!m_valid || ordy)});
        acc = iv && (!m_valid || ordy);
        op  = ir[15:12];
        s1  = int'(ir[8:6]);
        s2  = int'(ir[2:0]);
        m_illegal = 1'b0;
        if (rst) begin
            m_valid = 0; m_sr1 = 0; m_sr2 = 0; m_alu = 0; m_dr = 0;
            m_s1 = 0; m_s2 = -1;
            for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
        end else begin
            if (acc) begin
                if (op == 4'b0001 || op == 4'b0101 || op == 4'b1001) begin
                    if (m_valid && ordy) n_transfers++;
                    m_valid = 1;
                    m_dr  = ir[11:9];
                    m_sr1 = m_read(s1);
                    m_s1  = s1;
                    if (op == 4'b1001) begin
                        m_alu = 2'b10; m_sr2 = 16'h0; m_s2 = -1;
                    end else begin
                        m_alu = (op == 4'b0001) ? 2'b00 : 2'b01;
                        if (ir[5]) begin
                            m_sr2 = 16'(signed'(ir[4:0]));
                            m_s2  = -1;
                        end else begin
                            m_sr2 = m_read(s2);
                            m_s2  = s2;
                        end
                    end
                end else begin
                    if (m_valid && ordy) n_transfers++;
                    m_valid = 0;
                    m_illegal = 1;
                end
            end else if (m_valid && ordy) begin
                n_transfers++;
                m_valid = 0;
            end else if (m_valid && we) begin
                if (int'(wdr) == m_s1) m_sr1 = wd;
                if (int'(wdr) == m_s2) m_sr2 = wd;
            end
            if (we) m_rf[wdr] = wd;
        end
        @(posedge Clk);
        #1;
        chk("out_valid", {15'd0, out_valid}, {15'd0, m_valid});
        chk("illegal_op", {15'd0, illegal_op}, {15'd0, m_illegal});
        if (m_valid || rst) begin
            chk("SR1", SR1, m_sr1);
            chk("SR2", SR2, m_sr2);
            chk("ALUControl", {14'd0, ALUControl}, {14'd0, m_alu});
            chk("DR", {13'd0, DR}, {13'd0, m_dr});
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0, ordy);
    endtask

    initial begin
        logic [15:0] r_ir;
        logic [15:0] r_wd;
        logic [2:0]  r_dr;
        logic [3:0]  ops [4];
        int t0;
        ops[0] = 4'b0001; ops[1] = 4'b0101; ops[2] = 4'b1001; ops[3] = 4'b0010;
        m_valid = 0; m_sr1 = 0; m_sr2 = 0; m_alu = 0; m_dr = 0; m_illegal = 0;
        m_s1 = 0; m_s2 = -1; n_transfers = 0;
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
        Reset = 1; in_valid = 0; IR = 0; wb_en = 0; wb_dr = 0; wb_data = 0; out_ready = 1;

        // reset
        step(1'b1, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1);
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_SR1", SR1, 16'h0000);
        chk("rst_in_ready", {15'd0, in_ready}, 16'd1);

        // ADD R3,R1,R2
        step(1'b0, 1'b0, 16'h0, 1'b1, 3'd1, 16'h0005, 1'b1);
        step(1'b0, 1'b0, 16'h0, 1'b1, 3'd2, 16'h0003, 1'b1);
        step(1'b0, 1'b1, 16'h1642, 1'b0, 3'd0, 16'h0, 1'b1);
        chk("add_SR1", SR1, 16'h0005);
        chk("add_SR2", SR2, 16'h0003);
        chk("add_DR", {13'd0, DR}, 16'd3);

        // AND with imm -16, then NOT
        step(1'b0, 1'b1, 16'h5670, 1'b0, 3'd0, 16'h0, 1'b1);
        chk("and_imm_SR2", SR2, 16'hFFF0);
        chk("and_ctrl", {14'd0, ALUControl}, 16'd1);
        step(1'b0, 1'b1, 16'h967F, 1'b0, 3'd0, 16'h0, 1'b1);
        chk("not_SR1", SR1, 16'h0005);
        chk("not_SR2", SR2, 16'h0000);
        chk("not_ctrl", {14'd0, ALUControl}, 16'd2);

        // write-read bypass in the accept cycle
        step(1'b0, 1'b1, 16'h1642, 1'b1, 3'd1, 16'h1234, 1'b1);
        chk("bypass_SR1", SR1, 16'h1234);

        // backpressure hold with refresh of SR2 (R2)
        step(1'b0, 1'b1, 16'h1642, 1'b0, 3'd0, 16'h0, 1'b0);
        t0 = n_transfers;
        step(1'b0, 1'b1, 16'h5670, 1'b0, 3'd0, 16'h0, 1'b0);
        chk("hold_in_ready", {15'd0, in_ready}, 16'd0);
        step(1'b0, 1'b0, 16'h0, 1'b1, 3'd2, 16'hBEEF, 1'b0);
        chk("refresh_SR2", SR2, 16'hBEEF);
        chk("refresh_SR1", SR1, 16'h1234);
        chk("refresh_DR", {13'd0, DR}, 16'd3);
        step(1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);
        idle(1'b1);
        chk("hold_one_transfer", 16'(n_transfers - t0), 16'd1);
        chk("drained", {15'd0, out_valid}, 16'd0);

        // illegal opcode (LD)
        step(1'b0, 1'b1, 16'h2000, 1'b0, 3'd0, 16'h0, 1'b1);
        chk("ld_illegal", {15'd0, illegal_op}, 16'd1);
        idle(1'b1);
        chk("ld_pulse_end", {15'd0, illegal_op}, 16'd0);

        // random stream
        for (int n = 0; n < 400; n++) begin
            r_ir = 16'($urandom);
            r_ir[15:12] = ops[$urandom_range(0, 3)];
            r_wd = 16'($urandom);
            r_dr = 3'($urandom_range(0, 7));
            step(1'b0, 1'($urandom_range(0, 3) != 0), r_ir,
                 1'($urandom_range(0, 1)), r_dr, r_wd, 1'($urandom_range(0, 3) != 0));
        end

        // continuous ADD stream, then reset mid-stream
        for (int n = 0; n < 6; n++) begin
            r_ir = 16'($urandom);
            r_ir[15:12] = 4'b0001;
            step(1'b0, 1'b1, r_ir, 1'b0, 3'd0, 16'h0, 1'b1);
            chk("stream_valid", {15'd0, out_valid}, 16'd1);
        end
        step(1'b1, 1'b1, 16'h1642, 1'b1, 3'd1, 16'hAAAA, 1'b0);
        chk("midrst_valid", {15'd0, out_valid}, 16'd0);
        chk("midrst_SR1", SR1, 16'h0000);
        chk("midrst_DR", {13'd0, DR}, 16'd0);
        step(1'b0, 1'b1, 16'h1642, 1'b0, 3'd0, 16'h0, 1'b1);
        chk("midrst_R1", SR1, 16'h0000);
        chk("midrst_R2", SR2, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3_operand_stage.md
Name: lc3_operand_stage

Overview:
- Decode/operand-fetch stage directly upstream of the ALU.
- Accepts 16-bit LC-3 instruction words over a valid/ready handshake and decodes ADD/AND/NOT.
- Reads an internal 8x16 register file, sign-extends imm5, and presents registered SR1/SR2/ALUControl/DR to the ALU with 1-cycle latency.
- Owns the register-file write port; ALU results return on the writeback port.

Parameters:
- DATA_W, 16, datapath width; only 16 is supported.
- NUM_REGS, 8, register count; register index width is 3.

Ports:
- Clk  input  1  system clock, rising edge
- Reset  input  1  synchronous, active-high reset
- in_valid  input  1  IR holds an instruction
- in_ready  output  1  stage can accept IR this cycle
- IR  input  16  instruction word
- wb_en  input  1  register-file write enable
- wb_dr  input  3  write register index
- wb_data  input  16  write data (ALU result)
- out_valid  output  1  SR1/SR2/ALUControl/DR valid
- out_ready  input  1  ALU side accepts output
- SR1  output  16  operand 1
- SR2  output  16  operand 2 (register, sext(imm5), or 0)
- ALUControl  output  2  00 ADD, 01 AND, 10 NOT
- DR  output  3  destination register, IR[11:9]
- illegal_op  output  1  one-cycle pulse: accepted non-ALU opcode

Behaviour:
- Reset:
  - All 8 registers are 0.
  - out_valid=0, SR1=0, SR2=0, ALUControl=00, DR=0, illegal_op=0.
  - in_ready follows its combinational rule (1 after reset).
  - Reset mid-operation discards any held output and ignores same-cycle wb_en.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - Holding: while out_valid && !out_ready, all outputs hold stable (except the operand refresh below).
- Decode on accept, by opcode IR[15:12]:
  - 0001 ADD: ALUControl=00.
  - 0101 AND: ALUControl=01.
  - For both: SR1=R[IR[8:6]]; if IR[5]=1, SR2 = sign-extended IR[4:0]; else SR2=R[IR[2:0]].
  - 1001 NOT: ALUControl=10, SR1=R[IR[8:6]], SR2=16'h0000; IR[5:0] is not checked.
  - Any other opcode: consumed with no output; out_valid=0 next cycle; illegal_op=1 for exactly one cycle.
- out_valid:
  - Set the cycle after an ALU-opcode accept.
  - Cleared after a transfer with no new accept.
  - Back-to-back accept+transfer keeps out_valid=1, giving 1 instruction/cycle throughput.
- Register file:
  - Write on the rising edge when wb_en=1 (and Reset=0).
  - All 8 registers, including R0, are writable.
- Write-read bypass: if wb_en and wb_dr equals a source index in the accept cycle, that operand takes wb_data, not the stale register value.
- Held-entry refresh:
  - Applies while out_valid && !out_ready and a write to the held entry's SR1 index occurs, or to its SR2 index when SR2 is register-sourced.
  - The affected held operand is updated to wb_data on that edge.
  - Stored state per entry: src1 idx, src2 idx, imm flag.
- The same write feeding both SR1 and SR2 (identical indices) updates both.
- Arithmetic: none performed here; only sign extension (imm5 -16 to +15 maps to 16'hFFF0 through 16'h000F).

Decomposition:
- Package lc3_alu_pkg:
  - opcode constants OP_ADD=4'b0001, OP_AND=4'b0101, OP_NOT=4'b1001;
  - ALUControl enum ALU_ADD=2'b00, ALU_AND=2'b01, ALU_NOT=2'b10, ALU_PASS=2'b11;
  - typedef reg_idx_t [2:0], word_t [15:0].
- Sub-module lc3_regfile: 8x16, two async read ports, one sync write port, synchronous reset; bypass lives in lc3_operand_stage.

Test Plan:
- Reset, then write R1=16'h0005, R2=16'h0003; accept IR=16'h1642 (ADD R3,R1,R2) -> next cycle out_valid=1, SR1=0005, SR2=0003, ALUControl=00, DR=3.
- With R1=16'h0005, IR=16'h5670 (AND R3,R1,#-16) -> SR2=16'hFFF0, ALUControl=01; IR=16'h967F (NOT R3,R1) -> SR1=0005, SR2=0000, ALUControl=10.
- Accept cycle with wb_en=1, wb_dr=1, wb_data=16'h1234 while IR=16'h1642 -> SR1=1234, not the old R1 value.
- Hold out_ready=0 for 3 cycles after an ADD R3,R1,R2 accept; write R2=16'hBEEF mid-hold -> in_ready=0, SR2 becomes BEEF, SR1/DR unchanged; out_ready=1 transfers exactly once.
- IR=16'h2000 (LD) with in_valid=1 -> in_ready=1, illegal_op single pulse, out_valid stays 0.
- Continuous valid ADD stream with out_ready=1 -> one output per cycle; assert Reset mid-stream -> all outputs and registers 0 on the next cycle.
